// File: rtl/pulse_tx_if.sv
// Symbol request and pulse-line status bundle between a symbol source and pulse_tx.
// master = symbol source, slave = pulse_tx.
interface pulse_tx_if;
    logic       s1;
    logic       s0;
    logic       valid;
    logic       ready;
    logic       out;
    logic       busy;
    logic       done;
    logic [3:0] frame_cnt;

    modport master (
        output s1, s0, valid,
        input  ready, out, busy, done, frame_cnt
    );

    modport slave (
        input  s1, s0, valid,
        output ready, out, busy, done, frame_cnt
    );
endinterface

// File: rtl/pulse_tx.sv
// Pulse-width symbol transmitter: symbol N becomes a low pulse of N+1 cycles on an
// idle-high line, followed by GAP forced-high cycles and a one-cycle done strobe.
//
// state    | meaning
// ST_IDLE  | line high, ready for a symbol; done may be high in the first IDLE cycle
// ST_PULSE | line low, cnt counts remaining low cycles down to 0
// ST_GAP   | line high, gcnt counts remaining gap cycles down to 0
module pulse_tx #(
    parameter int unsigned GAP = 2
) (
    input  logic       clk,
    input  logic       reset,
    pulse_tx_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PULSE = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam logic [2:0] GAP_LOAD = 3'(GAP - 1);

    state_t     state_q;
    logic [1:0] cnt_q;
    logic [2:0] gcnt_q;
    logic       out_q;
    logic       done_q;
    logic [3:0] frame_cnt_q;
    logic [3:0] frame_cnt_d;

    // Modulo-16 frame counter wraps silently.
    assign frame_cnt_d = frame_cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            gcnt_q      <= 3'd0;
            out_q       <= 1'b1;
            done_q      <= 1'b0;
            frame_cnt_q <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    out_q <= 1'b1;
                    if (bus.valid) begin
                        cnt_q   <= {bus.s1, bus.s0};
                        state_q <= ST_PULSE;
                        out_q   <= 1'b0;
                    end
                end
                ST_PULSE: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= ST_GAP;
                        gcnt_q  <= GAP_LOAD;
                        out_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                        out_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    out_q <= 1'b1;
                    if (gcnt_q == 3'd0) begin
                        state_q     <= ST_IDLE;
                        done_q      <= 1'b1;
                        frame_cnt_q <= frame_cnt_d;
                    end else begin
                        gcnt_q <= gcnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    out_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out       = out_q;
    assign bus.done      = done_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: doc/pulse_tx.md
PULSE_TX -- requirements
Module: pulse_tx

Interface
REQ-001 Parameter: GAP, default 2, number of high (idle-level) cycles forced after each pulse; legal range 1..7.
REQ-002 Port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 Port: s1  input  1  symbol MSB.
REQ-005 Port: s0  input  1  symbol LSB; symbol N = {s1,s0}, 0..3.
REQ-006 Port: valid  input  1  symbol request; qualifies s1/s0.
REQ-007 Port: ready  output  1  high when a symbol can be accepted.
REQ-008 Port: out  output  1  serial line to the pulse-counting receiver; idle level 1, active level 0.
REQ-009 Port: busy  output  1  high while a frame (pulse or gap) is in progress.
REQ-010 Port: done  output  1  one-cycle strobe at frame completion.
REQ-011 Port: frame_cnt  output  4  count of completed frames, modulo 16.

Function
REQ-012 FSM states: IDLE, PULSE, GAP; 2-bit down-counter cnt; 3-bit gap counter gcnt.
REQ-013 ready SHALL be a pure decode of state==IDLE; busy SHALL be a pure decode of state!=IDLE; out, done and frame_cnt SHALL be registered.
REQ-014 Accept: posedge with state==IDLE and valid==1 -> latch N into cnt, state<=PULSE, out<=0.
REQ-015 valid while ready==0 SHALL be ignored (not queued); s1/s0 changes after accept SHALL NOT affect the frame in progress.
REQ-016 PULSE: at each posedge, if cnt==0 -> state<=GAP, gcnt<=GAP-1, out<=1; else cnt<=cnt-1, out stays 0.
REQ-017 Pulse width: out SHALL be 0 for exactly N+1 consecutive cycles, starting the cycle after acceptance.
REQ-018 GAP: out SHALL be 1; at each posedge, if gcnt==0 -> state<=IDLE, done<=1, frame_cnt<=frame_cnt+1; else gcnt<=gcnt-1.
REQ-019 GAP duration: exactly GAP cycles in state GAP.
REQ-020 done SHALL be high only in the first IDLE cycle after GAP and low in all other cycles.
REQ-021 Back-to-back: a symbol presented with valid in the same cycle that done is high SHALL be accepted at that cycle's closing edge; minimum high time between pulses is therefore GAP+1 cycles.
REQ-022 frame_cnt SHALL wrap 15 -> 0 with no flag.
REQ-023 In IDLE, out SHALL remain 1 and cnt/gcnt SHALL hold.
REQ-024 Unreachable state encodings SHALL return to IDLE with out<=1 at the next posedge.

Reset
REQ-025 Posedge with reset==1 SHALL force state=IDLE, out=1, done=0, frame_cnt=0, cnt=0, gcnt=0, with priority over every other condition, including acceptance.
REQ-026 Following reset, ready=1 and busy=0 in the first cycle with reset==0.
REQ-027 Reset asserted mid-PULSE or mid-GAP SHALL abort the frame: out returns to 1 at that posedge, no done strobe, no frame_cnt increment.
REQ-028 Without reset asserted, register contents are undefined; the bench SHALL apply reset for at least 1 cycle first.

Verification
REQ-029 Reset 2 cycles, then idle 3 cycles -> out=1, ready=1, busy=0, done=0, frame_cnt=0 throughout.
REQ-030 GAP=2, accept {s1,s0}=2'b10 -> out=0 for exactly 3 cycles, then 1 for 2 GAP cycles; done=1 in the next cycle; frame_cnt=1; ready low from acceptance until done.
REQ-031 Symbols 0,1,2,3 back-to-back with valid held high -> low pulses of 1,2,3,4 cycles, each separated by exactly 3 high cycles; frame_cnt=4; 4 done strobes.
REQ-032 Accept 2'b11, then assert reset in the 2nd low cycle -> out=1 at that edge, no done, frame_cnt=0, ready=1 after reset releases.
REQ-033 Accept 2'b00, toggle s1/s0 and pulse valid during PULSE/GAP -> single 1-cycle pulse, no extra frames, frame_cnt=1.
REQ-034 Send 17 frames of 2'b01 -> frame_cnt reads 1 after the 17th done (wrap confirmed); GAP=1 build shows 2 high cycles between pulses.
